// File: rtl/cw305_mbox_seq_if.sv
// rtl/cw305_mbox_seq_if.sv - mailbox bus and CPU doorbell between the host sequencer and the picorv32 side
`timescale 1ns/1ps
interface cw305_mbox_seq_if;
   logic        mbox_we;
   logic        mbox_re;
   logic [2:0]  mbox_addr;
   logic [31:0] mbox_wdata;
   logic [31:0] mbox_rdata;
   logic        cpu_go;
   logic        cpu_done;

   modport master (
      output mbox_we, mbox_re, mbox_addr, mbox_wdata, cpu_go,
      input  mbox_rdata, cpu_done
   );

   modport slave (
      input  mbox_we, mbox_re, mbox_addr, mbox_wdata, cpu_go,
      output mbox_rdata, cpu_done
   );
endinterface

// File: rtl/cw305_mbox_seq.sv
// rtl/cw305_mbox_seq.sv - host-side crypto mailbox sequencer: load pt, ring CPU, read back ct
// Optional build macro MBOX_SCRUB_EN: zero all 8 mailbox words after every operation.
`timescale 1ns/1ps
module cw305_mbox_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [127:0]     pt,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [127:0]     ct,
   cw305_mbox_seq_if.master mbox
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GO, S_READ, S_DONE, S_SCRUB} state_t;

   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

   state_t      state;
   logic [2:0]  idx;
   logic [31:0] wd_cnt;
   logic [95:0] pt_hi;
   logic [95:0] ct_lo;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         idx             <= '0;
         wd_cnt          <= '0;
         pt_hi           <= '0;
         ct_lo           <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         ct              <= '0;
         mbox.mbox_we    <= 1'b0;
         mbox.mbox_re    <= 1'b0;
         mbox.mbox_addr  <= '0;
         mbox.mbox_wdata <= '0;
         mbox.cpu_go     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !mbox.cpu_done) begin
                  pt_hi           <= pt[127:32];
                  err             <= 1'b0;
                  busy            <= 1'b1;
                  idx             <= '0;
                  mbox.mbox_we    <= 1'b1;
                  mbox.mbox_addr  <= 3'd0;
                  mbox.mbox_wdata <= pt[31:0];
                  state           <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (idx == 3'd3) begin
                  mbox.mbox_we    <= 1'b0;
                  mbox.mbox_addr  <= '0;
                  mbox.mbox_wdata <= '0;
                  mbox.cpu_go     <= 1'b1;
                  wd_cnt          <= '0;
                  state           <= S_GO;
               end else begin
                  idx             <= idx + 3'd1;
                  mbox.mbox_addr  <= idx + 3'd1;
                  mbox.mbox_wdata <= pt_hi[{idx[1:0], 5'd0} +: 32];
               end
            end
            S_GO: begin
               // A completion arriving on the expiry cycle still counts as success.
               if (mbox.cpu_done) begin
                  mbox.cpu_go    <= 1'b0;
                  mbox.mbox_re   <= 1'b1;
                  mbox.mbox_addr <= 3'd4;
                  idx            <= '0;
                  state          <= S_READ;
               end else if (WD_EN && wd_cnt == WD_LAST) begin
                  mbox.cpu_go <= 1'b0;
                  err         <= 1'b1;
                  ct          <= '0;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + 32'd1;
               end
            end
            S_READ: begin
               idx <= idx + 3'd1;
               if (idx < 3'd3) begin
                  mbox.mbox_addr <= 3'd5 + idx;
               end else begin
                  mbox.mbox_re   <= 1'b0;
                  mbox.mbox_addr <= '0;
               end
               // Read data trails its strobe by one cycle; ct moves only on the last word.
               if (idx == 3'd4) begin
                  ct    <= {mbox.mbox_rdata, ct_lo};
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (idx != 3'd0) begin
                  ct_lo[{idx[1:0] - 2'd1, 5'd0} +: 32] <= mbox.mbox_rdata;
               end
            end
            S_DONE: begin
               done <= 1'b0;
`ifdef MBOX_SCRUB_EN
               idx             <= '0;
               mbox.mbox_we    <= 1'b1;
               mbox.mbox_addr  <= 3'd0;
               mbox.mbox_wdata <= '0;
               state           <= S_SCRUB;
`else
               busy  <= 1'b0;
               state <= S_IDLE;
`endif
            end
            S_SCRUB: begin
               if (idx == 3'd7) begin
                  mbox.mbox_we   <= 1'b0;
                  mbox.mbox_addr <= '0;
                  busy           <= 1'b0;
                  state          <= S_IDLE;
               end else begin
                  idx            <= idx + 3'd1;
                  mbox.mbox_addr <= idx + 3'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cw305_mbox_seq.sv
// tb/tb_cw305_mbox_seq.sv - self-checking bench for cw305_mbox_seq with a mock mailbox and CPU
`timescale 1ns/1ps
module tb_cw305_mbox_seq;
   localparam int TO = 16;
`ifdef MBOX_SCRUB_EN
   localparam int SCRUB_N = 8;
`else
   localparam int SCRUB_N = 0;
`endif

   typedef struct {
      logic [127:0] p;
      logic [127:0] w;
      int           d;
      int           hold;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [127:0] pt;
   logic         busy;
   logic         done;
   logic         err;
   logic [127:0] ct;

   cw305_mbox_seq_if mbx ();

   cw305_mbox_seq #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .pt    (pt),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .ct    (ct),
      .mbox  (mbx.master)
   );

   always #5 clk = ~clk;

   // Mock mailbox: host-written words live in mem, CPU result words 4-7 come from cpu_w.
   logic [31:0] mem   [8];
   logic [31:0] cpu_w [4];
   always @(posedge clk) begin
      if (mbx.mbox_we) mem[mbx.mbox_addr] <= mbx.mbox_wdata;
      if (mbx.mbox_re) mbx.mbox_rdata <= mbx.mbox_addr[2] ? cpu_w[mbx.mbox_addr[1:0]] : mem[mbx.mbox_addr];
   end

   int           total = 0;
   int           bad   = 0;
   logic [127:0] exp_ct = '0;
   vec_t         tbl [6];

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] outs_now();
      return {87'd0, busy, done, err, mbx.cpu_go, mbx.mbox_we, mbx.mbox_re,
              mbx.mbox_addr, mbx.mbox_wdata, ct};
   endfunction

   // Cycle timeline derived from the start cycle: LOAD 1..4, GO from 5, READ G+1..G+5, DONE.
   task automatic run_op(input logic [127:0] p, input logic [127:0] w, input int d, input int hold);
      bit           ok;
      int           g, gend, dd, dend;
      logic         e_we, e_re, e_go;
      logic [2:0]   e_addr;
      logic [31:0]  e_wd;
      logic [127:0] e_ct;
      logic [127:0] e_mem;
      ok   = (d >= 0) && (d <= TO - 1);
      g    = 5 + d;
      gend = ok ? g : 4 + TO;
      dd   = ok ? g + 6 : gend + 1;
      dend = dd + SCRUB_N;
      for (int i = 0; i < 4; i++) cpu_w[i] = w[32*i +: 32];
      pt = p;
      start = 1'b1;
      mbx.cpu_done = 1'b0;
      step();
      for (int k = 1; k <= dend + 1; k++) begin
         mbx.cpu_done = ok && (k >= g) && (k < g + hold);
         start = (k <= dend) ? ($urandom_range(0, 3) == 0) : 1'b0;
         pt = {$urandom, $urandom, $urandom, $urandom};
         e_we = (k <= 4) || (k > dd && k <= dd + SCRUB_N);
         e_re = ok && (k > g) && (k <= g + 4);
         e_go = (k >= 5) && (k <= gend);
         e_addr = (k <= 4) ? 3'(k - 1) : e_re ? 3'(k - g + 3) : e_we ? 3'(k - dd - 1) : 3'd0;
         e_wd = (k <= 4) ? p[32*(k-1) +: 32] : 32'd0;
         e_ct = (k >= dd) ? (ok ? w : 128'd0) : exp_ct;
         check($sformatf("cyc k=%0d d=%0d", k, d), outs_now(),
               {87'd0, 1'(k <= dend), 1'(k == dd), 1'(k >= dd && !ok), e_go, e_we, e_re,
                e_addr, e_wd, e_ct});
         step();
      end
      exp_ct = ok ? w : 128'd0;
      e_mem = (SCRUB_N > 0) ? 128'd0 : p;
      check("mbox words 0-3", {128'd0, mem[3], mem[2], mem[1], mem[0]}, {128'd0, e_mem});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global timeout: sim did not reach the summary");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{128'h00112233_44556677_8899aabb_ccddeeff, {4{32'hdeadbeef}}, 3, 1};
      tbl[1] = '{128'hfeedface_0badf00d_13572468_a5a5a5a5, 128'h1, -1, 1};
      tbl[2] = '{128'h01020304_05060708_090a0b0c_0d0e0f10, 128'h11112222_33334444_55556666_77778888, TO - 1, 2};
      tbl[3] = '{128'hffffffff_00000000_ffffffff_00000000, 128'hcafef00d_00000001_80000000_7fffffff, 0, 5};
      tbl[4] = '{128'h5a5a5a5a_c3c3c3c3_3c3c3c3c_a5a5a5a5, 128'h2, -1, 1};
      tbl[5] = '{128'h89abcdef_01234567_fedcba98_76543210, 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0, TO - 2, 3};

      reset = 1'b1;
      start = 1'b0;
      pt = '0;
      mbx.cpu_done = 1'b0;
      for (int i = 0; i < 4; i++) cpu_w[i] = '0;
      step();
      step();
      check("reset state", outs_now(), 256'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_op(tbl[i].p, tbl[i].w, tbl[i].d, tbl[i].hold);

      // Start held while the CPU still signals done: must not be accepted.
      mbx.cpu_done = 1'b1;
      start = 1'b1;
      pt = 128'h1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("start blocked by cpu_done", {254'd0, busy, mbx.mbox_we}, 256'd0);
      end
      run_op(128'h00000004_00000003_00000002_00000001, 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa, 4, 1);

      // Reset after two READ strobes aborts everything on the next cycle.
      pt = 128'h77777777_66666666_55555555_44444444;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         mbx.cpu_done = (k == 7);
         reset = (k == 9);
         step();
      end
      check("reset mid-READ", outs_now(), 256'd0);
      reset = 1'b0;
      exp_ct = '0;
      step();
      run_op(128'h0000aaaa_0000bbbb_0000cccc_0000dddd, 128'h10203040_50607080_90a0b0c0_d0e0f000, 1, 1);

      for (int n = 0; n < 20; n++) begin
         run_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
                int'($urandom_range(1, 5)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
